// File: rtl/imem_loader.sv
// imem_loader: receives a program as a valid/ready byte stream, packs every
// IWIDTH/8 bytes big-endian into one instruction word and writes the words to
// instruction memory at consecutive addresses starting at 0. While a load is in
// progress the core's fetch stage is held in reset through cpu_hold_o.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to consume one trailing XOR
// checksum byte after the last word and report a mismatch on err_o.

module imem_loader #(
   parameter int IWIDTH = 24,
   parameter int PWIDTH = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [PWIDTH-1:0] len_i,
   input  logic              byte_valid_i,
   input  logic [7:0]        byte_data_i,
   output logic              byte_ready_o,
   output logic              we_o,
   output logic [PWIDTH-1:0] waddr_o,
   output logic [IWIDTH-1:0] wdata_o,
   output logic              busy_o,
   output logic              cpu_hold_o,
   output logic              done_o,
   output logic              err_o
);

   localparam int BPW = IWIDTH / 8;
   localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;

   typedef enum logic [2:0] {
      IDLE,
      RECV,
      WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK,
`endif
      DONE
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [PWIDTH-1:0] len_q;
   logic [PWIDTH-1:0] word_cnt;
   logic [BCW-1:0]    byte_cnt;
   logic [IWIDTH-1:0] buffer;
   logic [IWIDTH-1:0] buffer_shifted;
   logic [IWIDTH+7:0] buffer_wide;
   logic [PWIDTH-1:0] waddr_q;
   logic [IWIDTH-1:0] wdata_q;
   logic              ready;
   logic              write_en;
   logic              done;
   logic              last_byte;
   logic              last_word;
   logic              xfer;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        acc;
   logic              err_q;
`endif

   // Appending the new byte at the bottom and dropping the top byte makes the
   // first byte of a word end up as its MSB; the wide concatenation keeps this
   // valid even for single-byte words.
   assign buffer_wide    = {buffer, byte_data_i};
   assign buffer_shifted = buffer_wide[IWIDTH-1:0];

   assign xfer      = byte_valid_i & ready;
   assign last_byte = (byte_cnt == BCW'(BPW - 1));
   assign last_word = (word_cnt == (len_q - PWIDTH'(1)));

   // State register; reset drops straight back to IDLE from any state.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and per-state strobes (ready, write enable, done).
   always_comb begin
      state_next = state;
      ready      = 1'b0;
      write_en   = 1'b0;
      done       = 1'b0;
      unique case (state)
         IDLE: begin
            if (start_i) begin
               state_next = (len_i != '0) ? RECV : DONE;
            end
         end
         RECV: begin
            ready = 1'b1;
            if (byte_valid_i && last_byte) begin
               state_next = WRITE;
            end
         end
         WRITE: begin
            write_en = 1'b1;
            if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_next = CHECK;
`else
               state_next = DONE;
`endif
            end else begin
               state_next = RECV;
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         CHECK: begin
            ready = 1'b1;
            if (byte_valid_i) begin
               state_next = DONE;
            end
         end
`endif
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath: byte packing, word/byte counters and the registered write
   // address/data, which are captured on the last byte of a word so they are
   // valid throughout WRITE and hold their value afterwards.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         len_q    <= '0;
         word_cnt <= '0;
         byte_cnt <= '0;
         buffer   <= '0;
         waddr_q  <= '0;
         wdata_q  <= '0;
      end else begin
         if (state == IDLE && start_i) begin
            len_q    <= len_i;
            word_cnt <= '0;
            byte_cnt <= '0;
            buffer   <= '0;
         end
         if (state == RECV && xfer) begin
            buffer <= buffer_shifted;
            if (last_byte) begin
               byte_cnt <= '0;
               waddr_q  <= word_cnt;
               wdata_q  <= buffer_shifted;
            end else begin
               byte_cnt <= byte_cnt + BCW'(1);
            end
         end
         if (state == WRITE && !last_word) begin
            word_cnt <= word_cnt + PWIDTH'(1);
         end
      end
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   // Running XOR of every data byte of the current load, and the sticky
   // mismatch flag that is only cleared by the next accepted start.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc   <= '0;
         err_q <= 1'b0;
      end else begin
         if (state == IDLE && start_i) begin
            acc   <= '0;
            err_q <= 1'b0;
         end
         if (state == RECV && xfer) begin
            acc <= acc ^ byte_data_i;
         end
         if (state == CHECK && xfer) begin
            err_q <= (byte_data_i != acc);
         end
      end
   end

   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

   assign byte_ready_o = ready;
   assign we_o         = write_en;
   assign waddr_o      = waddr_q;
   assign wdata_o      = wdata_q;
   assign done_o       = done;
   assign busy_o       = (state != IDLE);
   assign cpu_hold_o   = (state != IDLE);

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader (IWIDTH=24, PWIDTH=16). Expected writes are queued
// when a load is driven and compared as the loader produces write strobes.
// Follows IMEM_LOADER_CHECKSUM_EN the same way the design does.

module tb_imem_loader;

   logic        clk_i;
   logic        rst_i;
   logic        start_i;
   logic [15:0] len_i;
   logic        byte_valid_i;
   logic [7:0]  byte_data_i;
   logic        byte_ready_o;
   logic        we_o;
   logic [15:0] waddr_o;
   logic [23:0] wdata_o;
   logic        busy_o;
   logic        cpu_hold_o;
   logic        done_o;
   logic        err_o;

   typedef struct {
      logic [15:0] addr;
      logic [23:0] data;
   } wr_t;

   wr_t        expQ[$];
   logic [7:0] streamBytes[$];
   int         checkCount = 0;
   int         passCount  = 0;

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam bit CK = 1'b1;
`else
   localparam bit CK = 1'b0;
`endif

   imem_loader #(.IWIDTH(24), .PWIDTH(16)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .start_i      (start_i),
      .len_i        (len_i),
      .byte_valid_i (byte_valid_i),
      .byte_data_i  (byte_data_i),
      .byte_ready_o (byte_ready_o),
      .we_o         (we_o),
      .waddr_o      (waddr_o),
      .wdata_o      (wdata_o),
      .busy_o       (busy_o),
      .cpu_hold_o   (cpu_hold_o),
      .done_o       (done_o),
      .err_o        (err_o)
   );

   // Free-running 10 ns clock.
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   // Hard stop in case something wedges despite the bounded waits.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed no finish expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Scoreboard side: every write strobe is matched against the oldest queued
   // expectation; ready must be low while writing.
   always @(negedge clk_i) begin
      if (!rst_i && we_o) begin
         checkOutput("ready_low_in_write", byte_ready_o, 1'b0);
         if (expQ.size() == 0) begin
            checkOutput("spurious_write", we_o, 1'b0);
         end else begin
            wr_t e;
            e = expQ.pop_front();
            checkOutput("waddr", waddr_o, e.addr);
            checkOutput("wdata", wdata_o, e.data);
         end
      end
   end

   task automatic sendByte(input logic [7:0] b, input int gap);
      int budget;
      for (int g = 0; g < gap; g++) begin
         @(negedge clk_i);
         byte_valid_i = 1'b0;
      end
      @(negedge clk_i);
      byte_valid_i = 1'b1;
      byte_data_i  = b;
      budget = 0;
      while (!byte_ready_o && budget < 50) begin
         @(negedge clk_i);
         budget++;
      end
      if (budget >= 50) checkOutput("ready_timeout", byte_ready_o, 1'b1);
   endtask

   task automatic startLoad(input logic [15:0] len);
      @(negedge clk_i);
      byte_valid_i = 1'b0;
      start_i      = 1'b1;
      len_i        = len;
      @(negedge clk_i);
      start_i = 1'b0;
      len_i   = 16'hFFFF;
      checkOutput("busy_after_start", busy_o, 1'b1);
      checkOutput("hold_after_start", cpu_hold_o, 1'b1);
      checkOutput("err_cleared", err_o, 1'b0);
      if (len != 16'd0) checkOutput("ready_after_start", byte_ready_o, 1'b1);
   endtask

   task automatic waitDone(input logic expErr, input int expLat);
      int cycles;
      cycles = 0;
      do begin
         @(negedge clk_i);
         byte_valid_i = 1'b0;
         cycles++;
      end while (!done_o && cycles < 200);
      checkOutput("done_seen", done_o, 1'b1);
      if (expLat > 0) checkOutput("done_latency", cycles, expLat);
      checkOutput("err_at_done", err_o, expErr);
      checkOutput("writes_drained", expQ.size(), 0);
      @(negedge clk_i);
      checkOutput("done_one_cycle", done_o, 1'b0);
      checkOutput("busy_release", busy_o, 1'b0);
      checkOutput("hold_release", cpu_hold_o, 1'b0);
   endtask

   // Drives one complete load from streamBytes, queuing the expected writes
   // and working out the checksum verdict independently.
   task automatic applyStimulus(input logic [15:0] len, input int gapMax, input logic [7:0] ckByte,
                                input int pulseAt, output logic expErr);
      logic [7:0] acc;
      wr_t        e;
      acc = 8'h00;
      for (int w = 0; w < int'(len); w++) begin
         e.addr = 16'(w);
         e.data = {streamBytes[3*w], streamBytes[3*w+1], streamBytes[3*w+2]};
         expQ.push_back(e);
      end
      startLoad(len);
      for (int i = 0; i < streamBytes.size(); i++) begin
         if (i == pulseAt) begin
            @(negedge clk_i);
            byte_valid_i = 1'b0;
            start_i      = 1'b1;
            len_i        = 16'd7;
            @(negedge clk_i);
            start_i = 1'b0;
         end
         sendByte(streamBytes[i], (gapMax > 0) ? int'($urandom_range(0, gapMax)) : 0);
         acc = acc ^ streamBytes[i];
      end
      expErr = 1'b0;
      if (CK) begin
         sendByte(ckByte, 0);
         expErr = (ckByte != acc);
      end
      waitDone(expErr, (gapMax == 0 && pulseAt < 0) ? (CK ? 1 : 2) : 0);
   endtask

   initial begin
      logic expErr;
      rst_i        = 1'b1;
      start_i      = 1'b0;
      len_i        = 16'd0;
      byte_valid_i = 1'b0;
      byte_data_i  = 8'h00;

      #12;
      checkOutput("rst_ready", byte_ready_o, 1'b0);
      checkOutput("rst_we", we_o, 1'b0);
      checkOutput("rst_waddr", waddr_o, 16'h0);
      checkOutput("rst_wdata", wdata_o, 24'h0);
      checkOutput("rst_busy", busy_o, 1'b0);
      checkOutput("rst_hold", cpu_hold_o, 1'b0);
      checkOutput("rst_done", done_o, 1'b0);
      checkOutput("rst_err", err_o, 1'b0);
      @(negedge clk_i);
      rst_i = 1'b0;

      $display("[TB] valid held high while idle");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         byte_valid_i = 1'b1;
         byte_data_i  = 8'hFF;
         checkOutput("idle_ready", byte_ready_o, 1'b0);
         checkOutput("idle_busy", busy_o, 1'b0);
      end

      $display("[TB] single-word load");
      streamBytes = '{8'hAB, 8'hCD, 8'hEF};
      applyStimulus(16'd1, 0, 8'h89, -1, expErr);

      $display("[TB] two words with random gaps");
      streamBytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      applyStimulus(16'd2, 3, 8'h77, -1, expErr);

      $display("[TB] bad checksum");
      applyStimulus(16'd2, 2, 8'h00, -1, expErr);
      repeat (3) @(negedge clk_i);
      checkOutput("err_sticky", err_o, expErr);

      $display("[TB] zero-length load");
      startLoad(16'd0);
      checkOutput("len0_done", done_o, 1'b1);
      checkOutput("len0_ready", byte_ready_o, 1'b0);
      @(negedge clk_i);
      checkOutput("len0_busy_one_cycle", busy_o, 1'b0);
      checkOutput("len0_done_one_cycle", done_o, 1'b0);
      checkOutput("len0_no_writes", expQ.size(), 0);

      $display("[TB] start pulsed during receive");
      streamBytes = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
      applyStimulus(16'd2, 0, 8'h70, 2, expErr);

      $display("[TB] reset in the middle of a load");
      begin
         wr_t e;
         e.addr = 16'd0;
         e.data = 24'hAABBCC;
         expQ.push_back(e);
      end
      startLoad(16'd3);
      sendByte(8'hAA, 0);
      sendByte(8'hBB, 0);
      sendByte(8'hCC, 0);
      sendByte(8'hDD, 0);
      @(negedge clk_i);
      byte_valid_i = 1'b0;
      checkOutput("pre_reset_busy", busy_o, 1'b1);
      #2 rst_i = 1'b1;
      #1;
      checkOutput("mid_rst_busy", busy_o, 1'b0);
      checkOutput("mid_rst_hold", cpu_hold_o, 1'b0);
      checkOutput("mid_rst_ready", byte_ready_o, 1'b0);
      checkOutput("mid_rst_wdata", wdata_o, 24'h0);
      checkOutput("mid_rst_waddr", waddr_o, 16'h0);
      checkOutput("mid_rst_we", we_o, 1'b0);
      checkOutput("mid_rst_done", done_o, 1'b0);
      checkOutput("mid_rst_err", err_o, 1'b0);
      checkOutput("mid_rst_drained", expQ.size(), 0);
      @(negedge clk_i);
      rst_i = 1'b0;
      streamBytes = '{8'h01, 8'h02, 8'h03};
      applyStimulus(16'd1, 0, 8'h00, -1, expErr);

      repeat (2) @(negedge clk_i);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction-memory loader: receives a program as a byte stream over a valid/ready handshake and packs every IWIDTH/8 bytes into one instruction word. Each word is written to the instruction memory's write port at consecutive addresses starting at 0. It is the write-side counterpart of the fetch stage's read-only instruction path. While it runs, it holds the core's fetch/PC logic in reset so that no instruction is fetched from a half-loaded image.

## Interface
- IWIDTH, 24, instruction width in bits; must be a multiple of 8. BPW = IWIDTH/8 bytes per word.
- PWIDTH, 16, address/PC width in bits.

- clk_i  in  1  clock; all state changes on its rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  begin a load; sampled only in IDLE.
- len_i  in  PWIDTH  number of words to load; sampled together with start_i.
- byte_valid_i  in  1  byte_data_i holds a valid byte.
- byte_data_i  in  8  stream byte.
- byte_ready_o  out  1  loader accepts a byte this cycle.
- we_o  out  1  instruction-memory write enable.
- waddr_o  out  PWIDTH  write address.
- wdata_o  out  IWIDTH  write data.
- busy_o  out  1  load in progress.
- cpu_hold_o  out  1  hold the fetch stage in reset; equals busy_o.
- done_o  out  1  one-cycle pulse at the end of a load.
- err_o  out  1  checksum mismatch flag; sticky until the next accepted start_i.

## Operation
- Reset value of every output is 0. Internal state: IDLE; word count, byte count, shift buffer and checksum accumulator are all 0.
- States: IDLE, RECV, WRITE, CHECK, DONE.
- IDLE:
  - byte_ready_o = 0.
  - start_i = 1 with len_i != 0 → RECV. Latch len_i. Clear counters and err_o.
  - start_i = 1 with len_i = 0 → DONE. Clear err_o; no writes are performed.
- RECV:
  - byte_ready_o = 1. A byte transfers when byte_valid_i & byte_ready_o.
  - On each transfer, the byte shifts into the buffer. The first byte of a word becomes the word's MSB (big-endian): buffer <= {buffer[IWIDTH-9:0], byte}.
  - The transfer of byte BPW-1 → WRITE.
- WRITE (1 cycle):
  - we_o = 1, waddr_o = word count, wdata_o = buffer; byte_ready_o = 0.
  - If word count = len-1 → CHECK (checksum compiled in) or DONE. Otherwise word count increments and the state returns to RECV.
- CHECK:
  - byte_ready_o = 1. Accepts exactly one byte.
  - err_o <= (byte != XOR of all data bytes of this load), then → DONE.
- DONE: done_o = 1 for one cycle → IDLE.
- busy_o = cpu_hold_o = (state != IDLE).
- start_i is ignored in every state other than IDLE.
- we_o is 0 in every state except WRITE. waddr_o and wdata_o hold their last values outside WRITE.
- Word count is PWIDTH bits wide; len_i = 2^PWIDTH-1 is the maximum load, and no wrap-around is possible.
- Reset mid-load returns to IDLE immediately with all outputs 0. Memory contents already written are left as they are, and the next load overwrites from address 0.
- Stalls on byte_valid_i = 0 are unbounded, and the loader waits in RECV/CHECK.

## Timing
- The last byte of a word transfers at edge N. we_o is high in the cycle after edge N; word count advances at edge N+1.
- Without checksum, the last byte of the last word transfers at edge N → done_o high in cycle N+2 → busy_o low from edge N+2.
- Peak throughput is one word per BPW+1 cycles, because byte_ready_o is low during WRITE.
- start_i in IDLE → busy_o high from the next edge. byte_ready_o goes high in the same cycle as busy_o.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - The CHECK state exists and one trailing XOR checksum byte is consumed after the last word.
  - err_o reports a mismatch; the data bytes are still written.
- IMEM_LOADER_CHECKSUM_EN undefined:
  - CHECK and the accumulator are removed, and WRITE of the last word goes directly to DONE.
  - err_o is tied to 0 and no trailing byte is consumed.

## Test plan
- Reset mid-load: assert rst_i after 4 bytes of a 3-word load → all outputs 0 asynchronously, state IDLE. A new 1-word load with bytes 01 02 03 → write 0x010203 @0.
- Single-word load, no stalls: start_i, len_i = 1, bytes AB CD EF → one we_o pulse with waddr_o = 0, wdata_o = 0xABCDEF. Checksum build then sends 0x89: err_o = 0, done_o 1 cycle later.
- Two words with random valid gaps: bytes 11 22 33 44 55 66 → writes 0x112233 @0 and 0x445566 @1, with byte_ready_o low during each WRITE cycle. Checksum byte 0x77 → err_o = 0.
- Bad checksum: same 2-word load with trailing byte 0x00 → both words written, err_o = 1 at done_o. err_o stays 1 until the next start_i, then clears.
- len_i = 0: start_i → no we_o pulse, done_o one cycle after start, busy_o high for exactly 1 cycle.
- start_i pulsed during RECV: no effect; the load completes with the original len_i. byte_valid_i held high in IDLE → no transfer, since byte_ready_o = 0.
